// File: rtl/writeback_pkg.sv
// Shared types for the writeback arbiter: channel indices, result word, instruction packet and FIFO entry.
package writeback_pkg;

   localparam int NUM_CHANNELS = 3;

   typedef enum logic [1:0] {
      ITU = 2'd0,
      LSU = 2'd1,
      CSR = 2'd2
   } channel_e;

   typedef logic [31:0] data_word_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic [4:0]  rob_tag;
      logic        exception_generated;
   } instr_packet_t;

   typedef struct packed {
      data_word_t    result;
      instr_packet_t ipacket;
   } wb_entry_t;

endpackage

// File: rtl/wb_channel_fifo.sv
// Per-channel result FIFO with flush, a registered almost-full flag and a combinational head.
// A push while full is accepted only when the same cycle also pops.
module wb_channel_fifo
   import writeback_pkg::*;
#(
   parameter int BUFFER_DEPTH = 4
) (
   input  logic      clk,
   input  logic      srst,
   input  logic      flush,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output logic      full,
   output logic      almost_full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int PTR_W = $clog2(BUFFER_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(BUFFER_DEPTH);
   localparam logic [PTR_W:0]   AF_LEVEL = (PTR_W+1)'(BUFFER_DEPTH - 1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   wb_entry_t        mem [BUFFER_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic [PTR_W:0]   count_next;
   logic             almost_full_reg;
   logic             do_push;
   logic             do_pop;

   assign empty       = (count_reg == '0);
   assign full        = (count_reg == DEPTH_C);
   assign almost_full = almost_full_reg;
   assign head        = mem[rd_ptr_reg];
   assign do_pop      = pop && !empty && !flush;
   assign do_push     = push && !flush && (!full || do_pop);

   always_comb begin
      count_next = count_reg;
      if (flush)
         count_next = '0;
      else if (do_push && !do_pop)
         count_next = count_reg + CNT_ONE;
      else if (!do_push && do_pop)
         count_next = count_reg - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= din;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         almost_full_reg <= 1'b0;
      end else begin
         count_reg       <= count_next;
         // Flag one slot early so a result already in flight still has room.
         almost_full_reg <= (count_next >= AF_LEVEL);
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the ITU/LSU/CSR result channels onto the single ROB writeback port via per-channel FIFOs
// and a round-robin arbiter. Optional macro WB_EXCEPTION_PRIORITY_EN lets excepting heads jump the queue.
module writeback_arbiter
   import writeback_pkg::*;
#(
   parameter int CHANNELS     = NUM_CHANNELS,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         stall_i,
   input  data_word_t    [CHANNELS-1:0] result_i,
   input  instr_packet_t [CHANNELS-1:0] ipacket_i,
   input  logic          [CHANNELS-1:0] data_valid_i,
   output logic          [CHANNELS-1:0] channel_full_o,
   output logic                         overflow_o,
   output data_word_t                   result_o,
   output instr_packet_t                ipacket_o,
   output logic                         data_valid_o
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   typedef logic [CH_W-1:0] ch_idx_t;
   localparam ch_idx_t LAST_CH = ch_idx_t'(CHANNELS - 1);
   localparam ch_idx_t CH_ONE  = ch_idx_t'(1);

   wb_entry_t           head [CHANNELS];
   logic [CHANNELS-1:0] fifo_full;
   logic [CHANNELS-1:0] fifo_empty;
   logic [CHANNELS-1:0] pop;
   logic [CHANNELS-1:0] drop;

   ch_idx_t       rr_ptr_reg;
   ch_idx_t       grant_idx;
   ch_idx_t       scan_idx;
   logic          grant_valid;
   logic          exc_grant;
   data_word_t    result_reg;
   instr_packet_t ipacket_reg;
   logic          data_valid_reg;
   logic          overflow_reg;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         wb_entry_t push_entry;
         assign push_entry = {result_i[gi], ipacket_i[gi]};
         assign pop[gi]    = grant_valid && !stall_i && !flush_i && (grant_idx == ch_idx_t'(gi));
         assign drop[gi]   = data_valid_i[gi] && fifo_full[gi] && !pop[gi] && !flush_i;

         wb_channel_fifo #(
            .BUFFER_DEPTH(BUFFER_DEPTH)
         ) u_fifo (
            .clk         (clk_i),
            .srst        (rst_i),
            .flush       (flush_i),
            .push        (data_valid_i[gi]),
            .din         (push_entry),
            .pop         (pop[gi]),
            .full        (fifo_full[gi]),
            .almost_full (channel_full_o[gi]),
            .empty       (fifo_empty[gi]),
            .head        (head[gi])
         );
      end
   endgenerate

   // Scan from the farthest candidate back to rr_ptr so the closest non-empty channel wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      exc_grant   = 1'b0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         scan_idx = ch_idx_t'((int'(rr_ptr_reg) + k) % CHANNELS);
         if (!fifo_empty[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
      end
`ifdef WB_EXCEPTION_PRIORITY_EN
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (!fifo_empty[ch_idx_t'(c)] && head[ch_idx_t'(c)].ipacket.exception_generated) begin
            grant_valid = 1'b1;
            grant_idx   = ch_idx_t'(c);
            exc_grant   = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_reg     <= '0;
         result_reg     <= '0;
         ipacket_reg    <= '0;
         data_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         if (|drop)
            overflow_reg <= 1'b1;
         if (flush_i) begin
            data_valid_reg <= 1'b0;
            rr_ptr_reg     <= '0;
         end else if (!stall_i) begin
            if (grant_valid) begin
               result_reg     <= head[grant_idx].result;
               ipacket_reg    <= head[grant_idx].ipacket;
               data_valid_reg <= 1'b1;
               if (!exc_grant)
                  rr_ptr_reg <= (grant_idx == LAST_CH) ? '0 : grant_idx + CH_ONE;
            end else begin
               result_reg     <= '0;
               ipacket_reg    <= '0;
               data_valid_reg <= 1'b0;
            end
         end
      end
   end

   assign result_o     = result_reg;
   assign ipacket_o    = ipacket_reg;
   assign data_valid_o = data_valid_reg;
   assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
   import writeback_pkg::*;

   localparam int CH    = NUM_CHANNELS;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush;
   logic                   stall;
   data_word_t    [CH-1:0] res_in;
   instr_packet_t [CH-1:0] pkt_in;
   logic          [CH-1:0] dv_in;
   logic          [CH-1:0] full_out;
   logic                   ovf_out;
   data_word_t             res_out;
   instr_packet_t          pkt_out;
   logic                   dv_out;

   int checks = 0;
   int errors = 0;

   // Reference model state: one queue per channel plus expected output registers.
   wb_entry_t     mq [CH][$];
   int            m_rr;
   logic          m_valid;
   logic          m_ovf;
   data_word_t    m_result;
   instr_packet_t m_pkt;
   logic [CH-1:0] m_full;

   always #5 clk = ~clk;

   writeback_arbiter #(
      .CHANNELS    (CH),
      .BUFFER_DEPTH(DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .stall_i        (stall),
      .result_i       (res_in),
      .ipacket_i      (pkt_in),
      .data_valid_i   (dv_in),
      .channel_full_o (full_out),
      .overflow_o     (ovf_out),
      .result_o       (res_out),
      .ipacket_o      (pkt_out),
      .data_valid_o   (dv_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic instr_packet_t mk_pkt(input logic exc);
      instr_packet_t p;
      p.pc                  = $urandom;
      p.rd_addr             = 5'($urandom);
      p.rob_tag             = 5'($urandom);
      p.exception_generated = exc;
      return p;
   endfunction

   task automatic idle_inputs();
      rst    = 1'b0;
      flush  = 1'b0;
      stall  = 1'b0;
      dv_in  = '0;
      res_in = '0;
      pkt_in = '0;
   endtask

   task automatic push(input int c, input data_word_t v, input logic exc);
      dv_in[c]  = 1'b1;
      res_in[c] = v;
      pkt_in[c] = mk_pkt(exc);
   endtask

   task automatic model_step();
      int        g;
      bit        exc;
      wb_entry_t e;
      if (rst) begin
         for (int c = 0; c < CH; c++) mq[c].delete();
         m_rr = 0; m_valid = 0; m_result = '0; m_pkt = '0; m_full = '0; m_ovf = 0;
         return;
      end
      if (flush) begin
         for (int c = 0; c < CH; c++) mq[c].delete();
         m_rr = 0; m_valid = 0; m_full = '0;
         return;
      end
      g   = -1;
      exc = 0;
`ifdef WB_EXCEPTION_PRIORITY_EN
      for (int c = 0; c < CH; c++)
         if (g < 0 && mq[c].size() > 0 && mq[c][0].ipacket.exception_generated) begin
            g = c; exc = 1;
         end
`endif
      for (int k = 0; k < CH; k++)
         if (g < 0 && mq[(m_rr + k) % CH].size() > 0) g = (m_rr + k) % CH;
      if (!stall) begin
         if (g >= 0) begin
            e        = mq[g].pop_front();
            m_result = e.result;
            m_pkt    = e.ipacket;
            m_valid  = 1;
            if (!exc) m_rr = (g + 1) % CH;
         end else begin
            m_valid = 0; m_result = '0; m_pkt = '0;
         end
      end
      for (int c = 0; c < CH; c++)
         if (dv_in[c]) begin
            if (mq[c].size() < DEPTH) mq[c].push_back({res_in[c], pkt_in[c]});
            else m_ovf = 1;
         end
      for (int c = 0; c < CH; c++) m_full[c] = (mq[c].size() >= DEPTH - 1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("valid", 64'(dv_out), 64'(m_valid));
      check("result", 64'(res_out), 64'(m_result));
      check("ipacket", 64'(pkt_out), 64'(m_pkt));
      check("chan_full", 64'(full_out), 64'(m_full));
      check("overflow", 64'(ovf_out), 64'(m_ovf));
      if (dv_out) $display("wb out: result=%08h rob_tag=%0d exc=%0b", res_out, pkt_out.rob_tag,
                           pkt_out.exception_generated);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      repeat (5) begin
         tick();
         check("idle_valid", 64'(dv_out), 64'(0));
         check("idle_full", 64'(full_out), 64'(0));
         check("idle_ovf", 64'(ovf_out), 64'(0));
      end

      // Single ITU result: one cycle of latency, then the port goes idle.
      push(ITU, 32'hDEAD_BEEF, 1'b0); tick(); idle_inputs();
      tick();
      check("single_valid", 64'(dv_out), 64'(1));
      check("single_result", 64'(res_out), 64'(32'hDEAD_BEEF));
      tick();
      check("single_gap", 64'(dv_out), 64'(0));

      // All three channels at once starting from rr_ptr=0.
      flush = 1'b1; tick(); idle_inputs();
      push(ITU, 32'h1111_1111, 1'b0); push(LSU, 32'h2222_2222, 1'b0); push(CSR, 32'h3333_3333, 1'b0);
      tick(); idle_inputs();
      tick(); check("rr_itu", 64'(res_out), 64'(32'h1111_1111));
      tick(); check("rr_lsu", 64'(res_out), 64'(32'h2222_2222));
      tick(); check("rr_csr", 64'(res_out), 64'(32'h3333_3333));
      tick(); check("rr_drain", 64'(dv_out), 64'(0));
      push(LSU, 32'h4444_4444, 1'b0); push(ITU, 32'h5555_5555, 1'b0); tick(); idle_inputs();
      tick(); check("rr_wrapped_itu", 64'(res_out), 64'(32'h5555_5555));
      tick(); check("rr_wrapped_lsu", 64'(res_out), 64'(32'h4444_4444));

      // Stall holds the output register with two ITU entries waiting.
      push(ITU, 32'hA000_000A, 1'b0); tick(); idle_inputs();
      push(ITU, 32'hB000_000B, 1'b0); tick(); idle_inputs();
      check("stall_pre", 64'(res_out), 64'(32'hA000_000A));
      push(ITU, 32'hC000_000C, 1'b0); stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); dv_in = '0;
         check("stall_hold", 64'(res_out), 64'(32'hA000_000A));
         check("stall_hold_valid", 64'(dv_out), 64'(1));
      end
      stall = 1'b0;
      tick(); check("stall_release", 64'(res_out), 64'(32'hB000_000B));
      tick(); check("stall_third", 64'(res_out), 64'(32'hC000_000C));

      // Fill LSU while stalled: almost-full after 3 pushes, overflow on the 5th.
      flush = 1'b1; tick(); idle_inputs();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(LSU, 32'h100 + i, 1'b0); tick(); dv_in = '0;
         check("lsu_almost_full", 64'(full_out[LSU]), 64'(i >= 2));
         check("lsu_overflow", 64'(ovf_out), 64'(i >= 4));
      end
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         tick(); check("lsu_drain", 64'(res_out), 64'(32'h100 + i));
      end
      tick(); check("lsu_dropped", 64'(dv_out), 64'(0));
      check("ovf_sticky", 64'(ovf_out), 64'(1));

      // Flush with three buffered entries and a simultaneous push.
      stall = 1'b1;
      push(ITU, 32'h1, 1'b0); push(LSU, 32'h2, 1'b0); push(CSR, 32'h3, 1'b0); tick(); idle_inputs();
      flush = 1'b1; push(ITU, 32'h9999_9999, 1'b0); tick(); idle_inputs();
      check("flush_valid", 64'(dv_out), 64'(0));
      check("flush_full", 64'(full_out), 64'(0));
      tick(); check("flush_empty", 64'(dv_out), 64'(0));

`ifdef WB_EXCEPTION_PRIORITY_EN
      stall = 1'b1;
      push(ITU, 32'h7777_7777, 1'b0); push(CSR, 32'h8888_8888, 1'b1); tick(); idle_inputs();
      tick(); check("exc_csr_first", 64'(res_out), 64'(32'h8888_8888));
      tick(); check("exc_itu_next", 64'(res_out), 64'(32'h7777_7777));
`endif

      // Randomized traffic against the model.
      rst = 1'b1; tick(); idle_inputs();
      check("reset_ovf_clear", 64'(ovf_out), 64'(0));
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(99) == 0);
         flush = ($urandom_range(24) == 0);
         stall = ($urandom_range(3) == 0);
         for (int c = 0; c < CH; c++) begin
            dv_in[c]  = 1'($urandom_range(1));
            res_in[c] = $urandom;
            pkt_in[c] = mk_pkt($urandom_range(7) == 0);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
